// File: rtl/cordic_engine_if.sv
// Operand/result bundle between a client and the CORDIC engine.
// The client drives ENABLE/MODE/operands; the engine returns results with Done/Busy/OVF.
interface cordic_engine_if #(
    parameter int WORD_LENGTH = 18
);
    logic                          ENABLE;
    logic                          MODE;
    logic signed [WORD_LENGTH-1:0] Xo;
    logic signed [WORD_LENGTH-1:0] Yo;
    logic signed [WORD_LENGTH-1:0] Zo;
    logic signed [WORD_LENGTH-1:0] XN;
    logic signed [WORD_LENGTH-1:0] YN;
    logic signed [WORD_LENGTH-1:0] ZN;
    logic                          Done;
    logic                          Busy;
    logic                          OVF;

    modport master (
        output ENABLE, MODE, Xo, Yo, Zo,
        input  XN, YN, ZN, Done, Busy, OVF
    );

    modport slave (
        input  ENABLE, MODE, Xo, Yo, Zo,
        output XN, YN, ZN, Done, Busy, OVF
    );
endinterface

// File: rtl/cordic_engine.sv
// Iterative rotation/vectoring CORDIC; Done pulses 1+R+ITERATIONS+1 cycles after accept (R = wraps+1).
// One operation in flight: ENABLE is only sampled in IDLE, there is no queueing.
module cordic_engine #(
    parameter int WORD_LENGTH = 18,
    parameter int FRAC_BITS   = 11,
    parameter int ITERATIONS  = 14,
    parameter int GAIN_COMP   = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    cordic_engine_if.slave bus
);
    localparam int  W     = WORD_LENGTH + 2;
    localparam int  PW    = W + FRAC_BITS + 5;
    localparam int  CW    = $clog2(ITERATIONS);
    localparam real SCALE = 2.0 ** FRAC_BITS;
    localparam int  PI_I  = $rtoi(3.141592653589793 * SCALE + 0.5);
    localparam int  HPI_I = $rtoi(1.5707963267948966 * SCALE + 0.5);
    localparam int  TPI_I = $rtoi(6.283185307179586 * SCALE + 0.5);
    localparam int  K_I   = $rtoi(0.6072529350088813 * SCALE * 16.0 + 0.5);

    localparam logic signed [W-1:0]  PI_C   = W'(PI_I);
    localparam logic signed [W-1:0]  HPI_C  = W'(HPI_I);
    localparam logic signed [W-1:0]  TPI_C  = W'(TPI_I);
    localparam logic signed [PW-1:0] SAT_HI = PW'((64'sd1 <<< (WORD_LENGTH - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

    // atan(2^-i) scaled by 2^30
    localparam longint ATAN30 [16] = '{
        843314857, 497837829, 263043837, 133525159, 67021687, 33543516, 16775851, 8388437,
        4194283, 2097149, 1048576, 524288, 262144, 131072, 65536, 32768
    };

    typedef enum logic [1:0] {IDLE, REDUCE, ITER, COMP} state_t;

    state_t                  state_q, state_d;
    logic                    mode_q, mode_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [W-1:0]     x_q, x_d, y_q, y_d, z_q, z_d;
    logic signed [WORD_LENGTH-1:0] xn_q, xn_d, yn_q, yn_d, zn_q, zn_d;
    logic                    done_q, done_d, ovf_q, ovf_d;

    logic signed [W-1:0]     xs, ys, at;
    logic                    rot_pos;
    logic signed [PW-1:0]    xk, yk;
    logic [WORD_LENGTH:0]    sx, sy, sz;

    function automatic logic signed [W-1:0] atan_q(input logic [CW-1:0] i);
        longint v;
        v = (ATAN30[i] + (64'sd1 <<< (29 - FRAC_BITS))) >>> (30 - FRAC_BITS);
        return W'(v);
    endfunction

    // {overflow flag, clipped value}
    function automatic logic [WORD_LENGTH:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_HI)
            return {1'b1, SAT_HI[WORD_LENGTH-1:0]};
        else if (v < SAT_LO)
            return {1'b1, SAT_LO[WORD_LENGTH-1:0]};
        return {1'b0, v[WORD_LENGTH-1:0]};
    endfunction

    always_comb begin
        xs      = x_q >>> cnt_q;
        ys      = y_q >>> cnt_q;
        at      = atan_q(cnt_q);
        rot_pos = mode_q ? y_q[W-1] : !z_q[W-1];
        if (GAIN_COMP != 0) begin
            xk = (PW'(x_q) * PW'(K_I)) >>> (FRAC_BITS + 4);
            yk = (PW'(y_q) * PW'(K_I)) >>> (FRAC_BITS + 4);
        end else begin
            xk = PW'(x_q);
            yk = PW'(y_q);
        end
        sx = sat(xk);
        sy = sat(yk);
        sz = sat(PW'(z_q));

        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xn_d    = xn_q;
        yn_d    = yn_q;
        zn_d    = zn_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.ENABLE) begin
                    x_d     = W'(bus.Xo);
                    y_d     = W'(bus.Yo);
                    z_d     = W'(bus.Zo);
                    mode_d  = bus.MODE;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                if (!mode_q) begin
                    if (z_q > PI_C) begin
                        z_d = z_q - TPI_C;
                    end else if (z_q < -PI_C) begin
                        z_d = z_q + TPI_C;
                    end else begin
                        // Fold into +-pi/2 so the iterations converge; negating X,Y adds the removed pi
                        if (z_q > HPI_C) begin
                            z_d = z_q - PI_C;
                            x_d = -x_q;
                            y_d = -y_q;
                        end else if (z_q < -HPI_C) begin
                            z_d = z_q + PI_C;
                            x_d = -x_q;
                            y_d = -y_q;
                        end
                        state_d = ITER;
                    end
                end else begin
                    if (x_q[W-1]) begin
                        x_d = -x_q;
                        y_d = -y_q;
                        z_d = y_q[W-1] ? z_q - PI_C : z_q + PI_C;
                    end
                    state_d = ITER;
                end
            end
            ITER: begin
                if (rot_pos) begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - at;
                end else begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + at;
                end
                if (cnt_q == CW'(ITERATIONS - 1))
                    state_d = COMP;
                else
                    cnt_d = cnt_q + CW'(1);
            end
            COMP: begin
                xn_d    = sx[WORD_LENGTH-1:0];
                yn_d    = sy[WORD_LENGTH-1:0];
                zn_d    = sz[WORD_LENGTH-1:0];
                ovf_d   = sx[WORD_LENGTH] | sy[WORD_LENGTH] | sz[WORD_LENGTH];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xn_q    <= '0;
            yn_q    <= '0;
            zn_q    <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xn_q    <= xn_d;
            yn_q    <= yn_d;
            zn_q    <= zn_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.XN   = xn_q;
    assign bus.YN   = yn_q;
    assign bus.ZN   = zn_q;
    assign bus.Done = done_q;
    assign bus.OVF  = ovf_q;
    assign bus.Busy = (state_q != IDLE);
endmodule
